// File: rtl/jtgng_ram_rdstream.sv
// Streams LEN consecutive words from the B port of the dual-clock RAM into a
// small FIFO and presents them as a valid/ready stream.
module jtgng_ram_rdstream #(
    parameter int DW      = 8,
    parameter int AW      = 10,
    parameter int FIFO_AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [DW-1:0] ram_q,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready
);

    localparam logic [FIFO_AW+1:0] DEPTH = (FIFO_AW+2)'(1) << FIFO_AW;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t               state, state_nx;
    logic [AW-1:0]        addr;
    logic [AW:0]          rd_left, pop_left;
    logic                 inflight;
    logic [DW-1:0]        mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count;
    logic [FIFO_AW+1:0]   occ;
    logic                 issue, push, pop;

    // Reserve a FIFO slot for the word still coming back from the RAM.
    assign occ        = {1'b0, count} + {{(FIFO_AW+1){1'b0}}, inflight};
    assign issue      = (state == READ) && (rd_left != '0) && (occ < DEPTH);
    assign push       = inflight;
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;

    assign ram_rd     = issue;
    assign ram_addr   = addr;
    assign busy       = (state == READ) || (state == DRAIN);
    assign done       = (state == DONE);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (len == '0) ? DONE : READ;
            READ:  if (issue && rd_left == (AW+1)'(1)) state_nx = DRAIN;
            DRAIN: if (pop_left == '0 || (pop && pop_left == (AW+1)'(1)))
                       state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            rd_left  <= '0;
            pop_left <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (cen) begin
            state    <= state_nx;
            inflight <= issue;
            if (state == IDLE && start) begin
                addr     <= base_addr;
                rd_left  <= len;
                pop_left <= len;
            end else begin
                if (issue) begin
                    addr    <= addr + AW'(1);
                    rd_left <= rd_left - (AW+1)'(1);
                end
                if (pop) pop_left <= pop_left - (AW+1)'(1);
            end
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push && !pop)      count <= count + (FIFO_AW+1)'(1);
            else if (pop && !push) count <= count - (FIFO_AW+1)'(1);
        end
    end

    // Storage needs no reset: dout is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (cen && push) mem[wr_ptr] <= ram_q;
    end

endmodule
